adc_ltc2308_scheduler: RTL and testbench

Sequencer in front of the LTC2308 SPI driver that scans an enabled-channel mask, in continuous or single-scan mode. It drives the driver's start/channel/sleep inputs and accounts for the ADC's one-frame config pipeline: the data read in frame N belongs to the channel configured in frame N-1. Each sample is tagged with its channel and buffered in a small FIFO with a valid/ready output handshake. Runs on the same 40 MHz clock as the driver (80-cycle frame, one-cycle adc_ready pulse per frame).

---
 rtl/adc_ltc2308_scheduler_if.sv | 18 +
 rtl/adc_ltc2308_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_adc_ltc2308_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ltc2308_scheduler_if.sv
// Sample stream from the LTC2308 scan scheduler: valid/ready handshake with a channel tag.
// With ADC_SCHED_TIMESTAMP_EN defined, each sample also carries its 16-bit frame stamp.
interface adc_ltc2308_scheduler_if;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_chan;
    logic        out_last;
`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [15:0] out_frame;

    modport master (output out_valid, out_data, out_chan, out_last, out_frame, input out_ready);
    modport slave  (input out_valid, out_data, out_chan, out_last, out_frame, output out_ready);
`else
    modport master (output out_valid, out_data, out_chan, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_chan, out_last, output out_ready);
`endif
endinterface

// File: rtl/adc_ltc2308_scheduler.sv
// Channel-scan sequencer for the LTC2308 SPI driver. It tracks the one-frame config pipeline and
// buffers the tagged samples in a FIFO. Optional ADC_SCHED_TIMESTAMP_EN adds a frame stamp.
module adc_ltc2308_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter bit IDLE_SLEEP = 1'b0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            mode,
    input  logic                            trigger,
    input  logic [7:0]                      chan_mask,
    output logic                            adc_start,
    output logic [3:0]                      adc_channel,
    output logic                            adc_sleep,
    input  logic                            adc_ready,
    input  logic [11:0]                     adc_data,
    output logic                            busy,
    output logic                            overflow,
    input  logic                            clear_overflow,
    adc_ltc2308_scheduler_if.master         stream
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  chan;
        logic        last;
`ifdef ADC_SCHED_TIMESTAMP_EN
        logic [15:0] frame;
`endif
    } entry_t;

    function automatic logic [2:0] first_chan(input logic [7:0] m);
        first_chan = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) first_chan = 3'(i);
    endfunction

    function automatic logic [2:0] highest_chan(input logic [7:0] m);
        highest_chan = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) highest_chan = 3'(i);
    endfunction

    // Lowest enabled channel above cur; caller handles the wrap case.
    function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
        next_chan = cur;
        for (int i = 7; i >= 0; i--)
            if (m[i] && i > int'(cur)) next_chan = 3'(i);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  chan_q, chan_d;
    logic [2:0]  pending_q, pending_d;
    logic        pending_last_q, pending_last_d;
    logic        push, push_last, at_top;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        mask_d         = mask_q;
        chan_d         = chan_q;
        pending_d      = pending_q;
        pending_last_d = pending_last_q;
        push           = 1'b0;
        push_last      = pending_last_q;
        at_top         = (chan_q == highest_chan(mask_q));

        case (state_q)
            S_IDLE: begin
                if (enable && chan_mask != 8'h00 && (!mode || trigger)) begin
                    state_d = S_PRIME;
                    mask_d  = chan_mask;
                    chan_d  = first_chan(chan_mask);
                end
            end
            S_PRIME, S_RUN: begin
                if (adc_ready) begin
                    // The strobe in PRIME returns data for an unknown earlier config; drop it.
                    push           = (state_q == S_RUN);
                    pending_d      = chan_q;
                    pending_last_d = at_top;
                    if (mode && at_top) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                        if (at_top) begin
                            if (chan_mask != 8'h00) mask_d = chan_mask;
                            chan_d = first_chan(mask_d);
                        end else begin
                            chan_d = next_chan(mask_q, chan_q);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (adc_ready) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d        = S_IDLE;
            mask_d         = mask_q;
            chan_d         = chan_q;
            pending_d      = pending_q;
            pending_last_d = pending_last_q;
            push           = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q        <= S_IDLE;
            mask_q         <= '0;
            chan_q         <= '0;
            pending_q      <= '0;
            pending_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            chan_q         <= chan_d;
            pending_q      <= pending_d;
            pending_last_q <= pending_last_d;
        end
    end

    assign adc_start   = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign adc_channel = {1'b0, chan_q};
    assign adc_sleep   = (state_q == S_IDLE) ? IDLE_SLEEP : 1'b0;

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          frame_cnt <= '0;
        else if (adc_ready) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry, head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && stream.out_ready;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = adc_data;
        wr_entry.chan = pending_q;
        wr_entry.last = push_last;
`ifdef ADC_SCHED_TIMESTAMP_EN
        wr_entry.frame = frame_cnt;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    // NOTE: the storage array is left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    assign head             = mem[rd_ptr[AW-1:0]];
    assign stream.out_valid = !empty;
    assign stream.out_data  = head.data;
    assign stream.out_chan  = head.chan;
    assign stream.out_last  = head.last;
`ifdef ADC_SCHED_TIMESTAMP_EN
    assign stream.out_frame = head.frame;
`endif

endmodule

// File: tb/tb_adc_ltc2308_scheduler.sv
// Directed self-checking bench for adc_ltc2308_scheduler: scan order, config pipeline,
// single-scan mode, backpressure/overflow, enable drop, async reset and optional frame stamps.
module tb_adc_ltc2308_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        mode;
    logic        trigger;
    logic [7:0]  chan_mask;
    logic        adc_start;
    logic [3:0]  adc_channel;
    logic        adc_sleep;
    logic        adc_ready;
    logic [11:0] adc_data;
    logic        busy;
    logic        overflow;
    logic        clear_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    adc_ltc2308_scheduler_if sif ();

    adc_ltc2308_scheduler #(
        .FIFO_DEPTH (4),
        .IDLE_SLEEP (1'b0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .trigger        (trigger),
        .chan_mask      (chan_mask),
        .adc_start      (adc_start),
        .adc_channel    (adc_channel),
        .adc_sleep      (adc_sleep),
        .adc_ready      (adc_ready),
        .adc_data       (adc_data),
        .busy           (busy),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .stream         (sif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One-cycle driver strobe; returns at the negedge of the cycle after it.
    task automatic strobe(input logic [11:0] d);
        adc_data  = d;
        adc_ready = 1'b1;
        @(negedge clock);
        adc_ready = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [2:0] ch, input logic [11:0] d,
                              input logic last);
        check({tag, " valid"}, sif.out_valid, 1'b1);
        check({tag, " chan"},  sif.out_chan,  ch);
        check({tag, " data"},  sif.out_data,  d);
        check({tag, " last"},  sif.out_last,  last);
        sif.out_ready = 1'b1;
        @(negedge clock);
        sif.out_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        mode           = 1'b0;
        trigger        = 1'b0;
        chan_mask      = 8'h00;
        adc_ready      = 1'b0;
        adc_data       = 12'h000;
        clear_overflow = 1'b0;
        sif.out_ready  = 1'b0;

        repeat (2) @(negedge clock);
        check("rst start",    adc_start,     1'b0);
        check("rst busy",     busy,          1'b0);
        check("rst channel",  adc_channel,   4'd0);
        check("rst sleep",    adc_sleep,     1'b0);
        check("rst valid",    sif.out_valid, 1'b0);
        check("rst overflow", overflow,      1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Continuous scan over channels 0,2,5 with data = frame index.
        enable    = 1'b1;
        chan_mask = 8'b0010_0101;
        @(negedge clock);
        check("cont start", adc_start,   1'b1);
        check("cont busy",  busy,        1'b1);
        check("cont ch0",   adc_channel, 4'd0);
        check("cont sleep", adc_sleep,   1'b0);
        strobe(12'd0);
        check("cont ch1", adc_channel, 4'd2);
        check("cont discard", sif.out_valid, 1'b0);
        strobe(12'd1);
        check("cont ch2", adc_channel, 4'd5);
        check("cont latency", sif.out_valid, 1'b1);
        strobe(12'd2);
        check("cont ch3", adc_channel, 4'd0);
        strobe(12'd3);
        check("cont ch4", adc_channel, 4'd2);
        strobe(12'd4);
        // Disable in RUN: idle next cycle, later strobes ignored, FIFO still drainable.
        enable = 1'b0;
        @(negedge clock);
        check("dis start", adc_start, 1'b0);
        check("dis busy",  busy,      1'b0);
        strobe(12'd9);
        check("dis overflow", overflow, 1'b0);
        pop_expect("cont s1", 3'd0, 12'd1, 1'b0);
        pop_expect("cont s2", 3'd2, 12'd2, 1'b0);
        pop_expect("cont s3", 3'd5, 12'd3, 1'b1);
        pop_expect("cont s4", 3'd0, 12'd4, 1'b0);
        check("cont empty", sif.out_valid, 1'b0);

        // Empty mask: a trigger must not start anything.
        mode      = 1'b1;
        chan_mask = 8'h00;
        enable    = 1'b1;
        trigger   = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
        @(negedge clock);
        check("mask0 busy", busy, 1'b0);

        // Single scan of channel 7, twice.
        chan_mask = 8'h80;
        @(negedge clock);
        check("single wait", busy, 1'b0);
        for (int r = 0; r < 2; r++) begin
            trigger = 1'b1;
            @(negedge clock);
            trigger = 1'b0;
            check("single busy", busy, 1'b1);
            check("single ch",   adc_channel, 4'd7);
            trigger = 1'b1;
            @(negedge clock);
            trigger = 1'b0;
            strobe(12'(10 + 2 * r));
            check("single discard", sif.out_valid, 1'b0);
            check("single busy2",   busy, 1'b1);
            strobe(12'(11 + 2 * r));
            check("single done busy",  busy,      1'b0);
            check("single done start", adc_start, 1'b0);
            pop_expect("single s", 3'd7, 12'(11 + 2 * r), 1'b1);
            check("single empty", sif.out_valid, 1'b0);
            repeat (2) @(negedge clock);
            check("single stays idle", busy, 1'b0);
        end

        // Backpressure: 6 samples into a 4-deep FIFO.
        mode      = 1'b0;
        chan_mask = 8'h01;
        @(negedge clock);
        for (int i = 0; i < 7; i++) strobe(12'(20 + i));
        enable = 1'b0;
        @(negedge clock);
        check("bp overflow", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pop_expect("bp pop", 3'd0, 12'(21 + i), 1'b1);
        check("bp empty", sif.out_valid, 1'b0);
        check("bp overflow sticky", overflow, 1'b1);
        clear_overflow = 1'b1;
        @(negedge clock);
        clear_overflow = 1'b0;
        check("bp cleared", overflow, 1'b0);

        // Full FIFO with push and pop in the same cycle: nothing lost.
        enable = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) strobe(12'(30 + i));
        check("pp head", sif.out_data, 12'd31);
        adc_data      = 12'd35;
        adc_ready     = 1'b1;
        sif.out_ready = 1'b1;
        @(negedge clock);
        adc_ready     = 1'b0;
        sif.out_ready = 1'b0;
        enable        = 1'b0;
        check("pp overflow", overflow, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) pop_expect("pp pop", 3'd0, 12'(32 + i), 1'b1);
        check("pp empty", sif.out_valid, 1'b0);

`ifdef ADC_SCHED_TIMESTAMP_EN
        force dut.frame_cnt = 16'hFFFE;
        @(negedge clock);
        release dut.frame_cnt;
        enable = 1'b1;
        @(negedge clock);
        strobe(12'd40);
        strobe(12'd41);
        strobe(12'd42);
        enable = 1'b0;
        @(negedge clock);
        check("ts frame0", sif.out_frame, 16'hFFFF);
        pop_expect("ts s0", 3'd0, 12'd41, 1'b1);
        check("ts frame1", sif.out_frame, 16'h0000);
        pop_expect("ts s1", 3'd0, 12'd42, 1'b1);
`endif

        // Asynchronous reset in the middle of a scan.
        chan_mask = 8'h03;
        enable    = 1'b1;
        @(negedge clock);
        strobe(12'd50);
        strobe(12'd51);
        check("mid valid", sif.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst start", adc_start,     1'b0);
        check("arst busy",  busy,          1'b0);
        check("arst valid", sif.out_valid, 1'b0);
        check("arst ovf",   overflow,      1'b0);
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("post rst valid", sif.out_valid, 1'b0);
        check("post rst busy",  busy,          1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
